// File: rtl/joystick_nav_repeat.sv
// Two-axis joystick to navigation button converter: hysteretic dead zone,
// hold qualification and typematic auto-repeat, one independent FSM per axis.

module joystick_axis_fsm #(
    parameter int unsigned ADC_W        = 10,
    parameter int unsigned LOW_TH       = 200,
    parameter int unsigned HIGH_TH      = 800,
    parameter int unsigned HYST         = 50,
    parameter int unsigned HOLD_CYC     = 5000,
    parameter int unsigned REPEAT_DELAY = 500000,
    parameter int unsigned REPEAT_RATE  = 100000,
    parameter int unsigned CNT_W        = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ADC_W-1:0] sample,
    input  logic             repeat_en,
    output logic             pulse_neg,
    output logic             pulse_pos,
    output logic             active
);

    typedef enum logic [1:0] {IDLE, HOLD, DELAY, REPEAT} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;   // 0: negative side, 1: positive side
    logic             fire;

    logic is_neg, is_pos, is_inner, same_side, opp_side;

    // Sample classification against the thresholds and release band
    always_comb begin
        is_neg    = sample < ADC_W'(LOW_TH);
        is_pos    = sample > ADC_W'(HIGH_TH);
        is_inner  = (sample >= ADC_W'(LOW_TH + HYST)) && (sample <= ADC_W'(HIGH_TH - HYST));
        same_side = dir_q ? is_pos : is_neg;
        opp_side  = dir_q ? is_neg : is_pos;
    end

    // Next-state, counter and pulse request
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        fire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_neg || is_pos) begin
                    state_d = HOLD;
                    dir_d   = is_pos;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (!same_side) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    fire    = 1'b1;
                    cnt_d   = '0;
                    state_d = DELAY;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DELAY: begin
                if (is_inner || opp_side) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!repeat_en) begin
                    cnt_d = '0;
                end else if (cnt_q == DELAY_LAST) begin
                    fire    = 1'b1;
                    cnt_d   = '0;
                    state_d = REPEAT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REPEAT: begin
                if (is_inner || opp_side) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!repeat_en) begin
                    state_d = DELAY;
                    cnt_d   = '0;
                end else if (cnt_q == RATE_LAST) begin
                    fire  = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter, direction and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            pulse_neg <= 1'b0;
            pulse_pos <= 1'b0;
            active    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            pulse_neg <= fire && !dir_q;
            pulse_pos <= fire && dir_q;
            active    <= (state_d != IDLE);
        end
    end

endmodule

module joystick_nav_repeat #(
    parameter int unsigned ADC_W        = 10,
    parameter int unsigned LOW_TH       = 200,
    parameter int unsigned HIGH_TH      = 800,
    parameter int unsigned HYST         = 50,
    parameter int unsigned HOLD_CYC     = 5000,
    parameter int unsigned REPEAT_DELAY = 500000,
    parameter int unsigned REPEAT_RATE  = 100000,
    parameter int unsigned CNT_W        = 24,
    parameter bit          Y_POS_IS_UP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ADC_W-1:0] x_axis_in,
    input  logic [ADC_W-1:0] y_axis_in,
    input  logic             repeat_en,
    output logic             btn_L_out,
    output logic             btn_R_out,
    output logic             btn_U_out,
    output logic             btn_D_out,
    output logic             x_active,
    output logic             y_active
);

    logic y_neg, y_pos;

    joystick_axis_fsm #(
        .ADC_W(ADC_W), .LOW_TH(LOW_TH), .HIGH_TH(HIGH_TH), .HYST(HYST),
        .HOLD_CYC(HOLD_CYC), .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE(REPEAT_RATE), .CNT_W(CNT_W)
    ) u_x (
        .clk(clk), .rst_n(rst_n), .sample(x_axis_in), .repeat_en(repeat_en),
        .pulse_neg(btn_L_out), .pulse_pos(btn_R_out), .active(x_active)
    );

    joystick_axis_fsm #(
        .ADC_W(ADC_W), .LOW_TH(LOW_TH), .HIGH_TH(HIGH_TH), .HYST(HYST),
        .HOLD_CYC(HOLD_CYC), .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE(REPEAT_RATE), .CNT_W(CNT_W)
    ) u_y (
        .clk(clk), .rst_n(rst_n), .sample(y_axis_in), .repeat_en(repeat_en),
        .pulse_neg(y_neg), .pulse_pos(y_pos), .active(y_active)
    );

    // Y orientation is a pure rewiring of already-registered pulses
    generate
        if (Y_POS_IS_UP) begin : g_y_up
            assign btn_U_out = y_pos;
            assign btn_D_out = y_neg;
        end else begin : g_y_down
            assign btn_U_out = y_neg;
            assign btn_D_out = y_pos;
        end
    endgenerate

endmodule

// File: tb/tb_joystick_nav_repeat.sv
// Bench for joystick_nav_repeat: directed scenarios plus randomized stick
// motion, checked every cycle against a timestamp-based behavioural model.

module tb_joystick_nav_repeat;

    localparam int HOLD = 4;
    localparam int RD   = 10;
    localparam int RR   = 3;
    localparam int LOW  = 200;
    localparam int HIGH = 800;
    localparam int HY   = 50;

    logic       clk;
    logic       rst_n;
    logic [9:0] x;
    logic [9:0] y;
    logic       repeat_en;
    logic       btn_l, btn_r, btn_u, btn_d, x_act, y_act;

    joystick_nav_repeat #(
        .ADC_W(10), .LOW_TH(LOW), .HIGH_TH(HIGH), .HYST(HY),
        .HOLD_CYC(HOLD), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
        .CNT_W(24), .Y_POS_IS_UP(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .x_axis_in(x), .y_axis_in(y),
        .repeat_en(repeat_en),
        .btn_L_out(btn_l), .btn_R_out(btn_r), .btn_U_out(btn_u), .btn_D_out(btn_d),
        .x_active(x_act), .y_active(y_act)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int t        = 0;

    // Model: side 0 none / 1 neg / 2 pos; post = first pulse already given
    int side[2], post[2], t_start[2], anchor[2];
    bit exp_neg[2], exp_pos[2];

    int l_cnt, r_cnt, u_cnt, d_cnt, last_l, last_r, last_d;
    int u_times[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, t, act, exp);
        end
    endtask

    // 1 NEG, 2 POS, 3 INNER, 0 BAND
    function automatic int cls(input logic [9:0] v);
        int iv = int'(v);
        if (iv < LOW) return 1;
        if (iv > HIGH) return 2;
        if (iv >= LOW + HY && iv <= HIGH - HY) return 3;
        return 0;
    endfunction

    function automatic void model_reset();
        for (int a = 0; a < 2; a++) begin
            side[a] = 0; post[a] = 0; t_start[a] = 0; anchor[a] = 0;
            exp_neg[a] = 1'b0; exp_pos[a] = 1'b0;
        end
    endfunction

    function automatic void fire(input int a);
        if (side[a] == 1) exp_neg[a] = 1'b1;
        else exp_pos[a] = 1'b1;
    endfunction

    // Pulse times follow from the hold start and the last repeat anchor
    function automatic void axis_step(input int a, input int c, input bit en);
        int k;
        exp_neg[a] = 1'b0;
        exp_pos[a] = 1'b0;
        if (side[a] == 0) begin
            if (c == 1 || c == 2) begin
                side[a] = c; post[a] = 0; t_start[a] = t;
            end
        end else if (post[a] == 0) begin
            if (c != side[a]) side[a] = 0;
            else if (t - t_start[a] == HOLD) begin
                fire(a); post[a] = 1; anchor[a] = t;
            end
        end else begin
            if (c == 3 || c == 3 - side[a]) side[a] = 0;
            else if (!en) anchor[a] = t;
            else begin
                k = t - anchor[a];
                if (k == RD || (k > RD && (k - RD) % RR == 0)) fire(a);
            end
        end
    endfunction

    task automatic cycle();
        logic [5:0] got, expv;
        @(posedge clk);
        t++;
        axis_step(0, cls(x), repeat_en);
        axis_step(1, cls(y), repeat_en);
        @(negedge clk);
        got  = {btn_l, btn_r, btn_u, btn_d, x_act, y_act};
        expv = {exp_neg[0], exp_pos[0], exp_pos[1], exp_neg[1], side[0] != 0, side[1] != 0};
        chk("outputs_LRUDxy", int'(got), int'(expv));
        if (btn_l) begin l_cnt++; last_l = t; end
        if (btn_r) begin r_cnt++; last_r = t; end
        if (btn_u) begin u_cnt++; u_times.push_back(t); end
        if (btn_d) begin d_cnt++; last_d = t; end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Asynchronous reset asserted between clock edges
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 chk("async_reset_clears", int'({btn_l, btn_r, btn_u, btn_d, x_act, y_act}), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("reset_held", int'({btn_l, btn_r, btn_u, btn_d, x_act, y_act}), 0);
        rst_n = 1'b1;
    endtask

    function automatic logic [9:0] pick();
        int b[10] = '{0, 199, 200, 249, 250, 750, 751, 800, 801, 1023};
        case ($urandom_range(0, 9))
            0, 1:    return 10'($urandom_range(0, 199));
            2:       return 10'($urandom_range(200, 249));
            3:       return 10'($urandom_range(250, 750));
            4:       return 10'($urandom_range(751, 800));
            5, 6:    return 10'($urandom_range(801, 1023));
            default: return 10'(b[$urandom_range(0, 9)]);
        endcase
    endfunction

    initial begin
        int t0, l0, r0, u0;
        int exp_u[4] = '{4, 14, 17, 20};
        rst_n = 1'b0; x = 10'd512; y = 10'd512; repeat_en = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_state", int'({btn_l, btn_r, btn_u, btn_d, x_act, y_act}), 0);
        rst_n = 1'b1;

        // One pulse per deflection with repeat disabled, re-arm after release
        x = 10'd100; t0 = t + 1; l0 = l_cnt;
        run(104);
        chk("t1_single_L", l_cnt - l0, 1);
        chk("t1_L_latency", last_l - t0, 4);
        x = 10'd512; run(1);
        x = 10'd100; t0 = t + 1; l0 = l_cnt;
        run(10);
        chk("t1_second_L", l_cnt - l0, 1);
        chk("t1_second_latency", last_l - t0, 4);

        // Short glitch rejected
        x = 10'd900; r0 = r_cnt;
        run(3);
        x = 10'd512; run(2);
        chk("t2_no_R", r_cnt - r0, 0);
        chk("t2_x_idle", int'(x_act), 0);

        // Auto-repeat cadence on Y
        repeat_en = 1'b1; y = 10'd1000; t0 = t + 1; u_times.delete();
        run(21);
        chk("t3_U_count", u_times.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("t3_U_time", (i < u_times.size()) ? u_times[i] - t0 : -1, exp_u[i]);
        y = 10'd512; u0 = u_cnt;
        run(10);
        chk("t3_U_stops", u_cnt - u0, 0);

        // Hysteresis: BAND holds, INNER releases, BAND aborts hold
        repeat_en = 1'b0; x = 10'd100;
        run(5);
        x = 10'd220; l0 = l_cnt;
        run(30);
        chk("t4_band_no_pulse", l_cnt - l0, 0);
        chk("t4_band_active", int'(x_act), 1);
        x = 10'd260; run(1);
        chk("t4_inner_idle", int'(x_act), 0);
        x = 10'd100; l0 = l_cnt; run(2);
        x = 10'd230; run(5);
        chk("t4_abort_no_pulse", l_cnt - l0, 0);
        chk("t4_abort_idle", int'(x_act), 0);

        // Opposite-side swing
        x = 10'd100; run(5);
        x = 10'd900; t0 = t + 1; l0 = l_cnt; r0 = r_cnt;
        run(1);
        chk("t5_swing_idle", int'(x_act), 0);
        run(6);
        chk("t5_R_once", r_cnt - r0, 1);
        chk("t5_R_time", last_r - t0, 5);
        chk("t5_no_L", l_cnt - l0, 0);

        // Simultaneous axes and reset mid-repeat
        x = 10'd512; y = 10'd512; run(2);
        x = 10'd100; y = 10'd50; t0 = t + 1;
        run(5);
        chk("t6_L_time", last_l - t0, 4);
        chk("t6_D_time", last_d - t0, 4);
        repeat_en = 1'b1;
        run(16);
        do_reset();
        t0 = t + 1; l0 = l_cnt;
        run(6);
        chk("t6_post_reset_L", l_cnt - l0, 1);
        chk("t6_post_reset_latency", last_l - t0, 4);
        chk("t6_post_reset_D", last_d - t0, 4);

        // Randomized stick motion
        for (int s = 0; s < 150; s++) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            if ($urandom_range(0, 4) != 0) x = pick();
            if ($urandom_range(0, 4) != 0) y = pick();
            repeat_en = ($urandom_range(0, 3) != 0);
            run(int'($urandom_range(1, 40)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/joystick_nav_repeat.md
Name: joystick_nav_repeat

Overview:
Parametrised two-axis joystick-to-navigation-button converter. It feeds the LCD menu controller from the ADC joystick samples.
- Independent X and Y FSMs, so there is no cross-axis coupling.
- Hysteretic dead zone and per-direction hold qualification.
- Typematic auto-repeat while the stick stays deflected.
- Outputs are single-cycle button pulses, the same contract the menu logic already consumes.

Parameters:
ADC_W, 10, sample width of x_axis_in/y_axis_in (unsigned).
LOW_TH, 200, negative-side threshold; a value below it is deflected negative.
HIGH_TH, 800, positive-side threshold; a value above it is deflected positive.
HYST, 50, release band; release only when LOW_TH+HYST <= v <= HIGH_TH-HYST.
HOLD_CYC, 5000, cycles a deflection must persist before the first pulse (>=1).
REPEAT_DELAY, 500000, cycles after the first pulse before the first repeat pulse (>=1).
REPEAT_RATE, 100000, cycles between subsequent repeat pulses (>=1).
CNT_W, 24, counter width; must hold max(HOLD_CYC, REPEAT_DELAY, REPEAT_RATE).
Y_POS_IS_UP, 1, 1: y>HIGH_TH gives btn_U and y<LOW_TH gives btn_D; 0: swapped.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
x_axis_in  in  ADC_W  X sample (low = left)
y_axis_in  in  ADC_W  Y sample
repeat_en  in  1  1 enables auto-repeat; 0 gives one pulse per deflection
btn_L_out  out  1  one-cycle left pulse
btn_R_out  out  1  one-cycle right pulse
btn_U_out  out  1  one-cycle up pulse
btn_D_out  out  1  one-cycle down pulse
x_active  out  1  X axis FSM not in IDLE
y_active  out  1  Y axis FSM not in IDLE

Behaviour:
- One clock, clk. rst_n is asynchronous and active-low.
- Reset: both FSMs go to IDLE, counters and latched direction go to 0, and all outputs go to 0.
- All outputs are registered. Pulses are default-0 each cycle and high for exactly one cycle.
- Per-axis classification (v = sample):
  - NEG if v < LOW_TH.
  - POS if v > HIGH_TH.
  - INNER if LOW_TH+HYST <= v <= HIGH_TH-HYST.
  - otherwise BAND.
- Per-axis FSM states: IDLE, HOLD, DELAY, REPEAT. There is one counter cnt and one latched direction dir.
- IDLE:
  - on NEG or POS: dir <= that side, cnt <= 0, go to HOLD.
  - on BAND or INNER: stay in IDLE.
- HOLD:
  - if the class is not dir (INNER, BAND or the opposite side): go to IDLE, no pulse.
  - else if cnt == HOLD_CYC-1: pulse the dir button, cnt <= 0, go to DELAY.
  - else cnt++.
  - First-pulse latency: the pulse is high in cycle N+HOLD_CYC, where edge N is the first edge that samples the deflection.
- DELAY and REPEAT:
  - INNER: go to IDLE.
  - Opposite side (NEG<->POS): go to IDLE. The new side then gets its full hold qualification starting from IDLE.
  - BAND or same side: stay in the state and keep counting.
- DELAY counting:
  - repeat_en=0: cnt is held at 0 and no pulses are produced.
  - repeat_en=1: when cnt == REPEAT_DELAY-1, pulse, cnt <= 0, go to REPEAT; else cnt++.
- REPEAT counting:
  - repeat_en=1: when cnt == REPEAT_RATE-1, pulse, cnt <= 0; else cnt++.
  - repeat_en=0: go to DELAY with cnt <= 0.
- Pulses never occur in the same cycle as a transition to IDLE.
- The direction pulse is taken from the latched dir, not re-derived from the sample. L and R can never both be high; U and D can never both be high.
- The two axes are fully independent: X and Y may pulse in the same cycle.
- x_active and y_active are registered and equal (state != IDLE).
- Reset mid-hold or mid-repeat aborts immediately with no pulse. After release, a stick still deflected needs a full HOLD_CYC again.
- Comparisons are unsigned, at full ADC_W width. Thresholds are assumed to satisfy LOW_TH+HYST < HIGH_TH-HYST. The counter never wraps, because the compare is at the terminal value.

Test Plan:
Bench parameters: HOLD_CYC=4, REPEAT_DELAY=10, REPEAT_RATE=3.
1. x=100 held, repeat_en=0. Expect:
   - btn_L_out high exactly once, 4 cycles after the first sampling edge.
   - no further pulses over 100 cycles.
   - then x=512 for 1 cycle, then x=100 again: a second btn_L_out after 4+1 cycles.
2. x=900 for 3 cycles, then x=512. Expect no btn_R_out and x_active low again; the short glitch is rejected.
3. y=1000, repeat_en=1, Y_POS_IS_UP=1. Expect btn_U_out at cycles 4, 14, 17, 20, ... until y=512, then nothing further.
4. Hysteresis check: x=100 until the first L pulse, then x=220 (BAND) for 30 cycles, then x=260 (INNER).
   - Expect no extra pulse in BAND with repeat_en=0.
   - Expect IDLE after 260.
   - Also x=100 then x=230 before HOLD completes: expect abort, no pulse.
5. Opposite-side swing: x=100 until the first L pulse, then x=900 directly. Expect IDLE for one cycle, then btn_R_out 4 cycles after HOLD entry, and no L pulse after the swing.
6. Simultaneous axes plus reset:
   - x=100 and y=50 together: btn_L_out and btn_D_out in the same cycle.
   - rst_n low mid-REPEAT: all outputs 0 immediately (asynchronously).
   - After release, with the stick still held: the first pulse comes HOLD_CYC cycles later.
